// File: rtl/id_stage.sv
// rtl/id_stage.sv - MIPS decode stage: register file, control decode, ID-resolved jumps, hazard stalls, ID/EX register
// Build option: REGFILE_BYPASS_EN makes the register file write-first; without it a WB-to-ID match stalls one cycle.
module id_stage #(
  parameter logic [4:0]  LINK_REG = 5'd31,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] if_id_pc4,
  input  logic [31:0] if_id_instr,
  input  logic        ex_dobranch,
  input  logic        wb_regwrite,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        pc_keep,
  output logic        dojump,
  output logic [31:0] jumpaddress,
  output logic [1:0]  next_condition,
  output logic [31:0] id_ex_pc4,
  output logic [31:0] id_ex_rs_data,
  output logic [31:0] id_ex_rt_data,
  output logic [31:0] id_ex_imm,
  output logic [4:0]  id_ex_rs,
  output logic [4:0]  id_ex_rt,
  output logic [4:0]  id_ex_rd,
  output logic [11:0] id_ex_ctrl
);

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08, OP_ANDI = 6'h0C, OP_ORI = 6'h0D, OP_LUI = 6'h0F;
  localparam logic [5:0] OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] FN_JR = 6'h08, FN_ADD = 6'h20, FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24, FN_OR = 6'h25, FN_SLT = 6'h2A;
  localparam logic [3:0] ALU_NONE = 4'd0, ALU_ADD = 4'd1, ALU_SUB = 4'd2, ALU_AND = 4'd3;
  localparam logic [3:0] ALU_OR = 4'd4, ALU_SLT = 4'd5, ALU_LUI = 4'd6;
  localparam logic [1:0] NC_GO = 2'b00, NC_FLUSH = 2'b01, NC_KEEP = 2'b10;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] rf_q [32];
  logic [31:0] rs_data, rt_data;

  logic        valid, uses_rt, is_j, is_jal, is_jr;
  logic        regwrite, memread, memwrite, alusrc, branch, regdst_rd;
  logic [1:0]  memtoreg;
  logic [3:0]  aluop;
  logic [31:0] imm_ext;
  logic [4:0]  dest;
  logic        rt_used, load_use, jr_hazard, wb_hazard, stall, jump, bubble;

  logic [31:0] id_ex_pc4_q, id_ex_pc4_d, id_ex_rs_data_q, id_ex_rs_data_d;
  logic [31:0] id_ex_rt_data_q, id_ex_rt_data_d, id_ex_imm_q, id_ex_imm_d;
  logic [4:0]  id_ex_rs_q, id_ex_rs_d, id_ex_rt_q, id_ex_rt_d, id_ex_rd_q, id_ex_rd_d;
  logic [11:0] id_ex_ctrl_q, id_ex_ctrl_d;

  assign opcode = if_id_instr[31:26];
  assign funct  = if_id_instr[5:0];
  assign rs     = if_id_instr[25:21];
  assign rt     = if_id_instr[20:16];
  assign rd     = if_id_instr[15:11];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (wb_regwrite && wb_rd != 5'd0) begin
      rf_q[wb_rd] <= wb_data;
    end
  end

`ifdef REGFILE_BYPASS_EN
  always_comb begin
    rs_data = (rs == 5'd0) ? '0 : rf_q[rs];
    rt_data = (rt == 5'd0) ? '0 : rf_q[rt];
    if (wb_regwrite && wb_rd != 5'd0 && wb_rd == rs) rs_data = wb_data;
    if (wb_regwrite && wb_rd != 5'd0 && wb_rd == rt) rt_data = wb_data;
  end
`else
  always_comb begin
    rs_data = (rs == 5'd0) ? '0 : rf_q[rs];
    rt_data = (rt == 5'd0) ? '0 : rf_q[rt];
  end
`endif

  always_comb begin
    valid     = 1'b1;
    uses_rt   = 1'b0;
    is_j      = 1'b0;
    is_jal    = 1'b0;
    is_jr     = 1'b0;
    regwrite  = 1'b0;
    memread   = 1'b0;
    memwrite  = 1'b0;
    memtoreg  = 2'b00;
    alusrc    = 1'b0;
    branch    = 1'b0;
    aluop     = ALU_NONE;
    regdst_rd = 1'b0;
    imm_ext   = {{16{if_id_instr[15]}}, if_id_instr[15:0]};
    case (opcode)
      OP_RTYPE: begin
        uses_rt   = 1'b1;
        regwrite  = 1'b1;
        regdst_rd = 1'b1;
        case (funct)
          FN_ADD: aluop = ALU_ADD;
          FN_SUB: aluop = ALU_SUB;
          FN_AND: aluop = ALU_AND;
          FN_OR:  aluop = ALU_OR;
          FN_SLT: aluop = ALU_SLT;
          FN_JR: begin
            is_jr     = 1'b1;
            regwrite  = 1'b0;
            regdst_rd = 1'b0;
          end
          default: valid = 1'b0;
        endcase
      end
      OP_LW: begin
        regwrite = 1'b1; memread = 1'b1; memtoreg = 2'b01; alusrc = 1'b1; aluop = ALU_ADD;
      end
      OP_SW: begin
        uses_rt = 1'b1; memwrite = 1'b1; alusrc = 1'b1; aluop = ALU_ADD;
      end
      OP_BEQ: begin
        uses_rt = 1'b1; branch = 1'b1; aluop = ALU_SUB;
      end
      OP_ADDI: begin
        regwrite = 1'b1; alusrc = 1'b1; aluop = ALU_ADD;
      end
      OP_ANDI: begin
        regwrite = 1'b1; alusrc = 1'b1; aluop = ALU_AND; imm_ext = {16'h0, if_id_instr[15:0]};
      end
      OP_ORI: begin
        regwrite = 1'b1; alusrc = 1'b1; aluop = ALU_OR; imm_ext = {16'h0, if_id_instr[15:0]};
      end
      OP_LUI: begin
        regwrite = 1'b1; alusrc = 1'b1; aluop = ALU_LUI; imm_ext = {if_id_instr[15:0], 16'h0};
      end
      OP_J:   is_j = 1'b1;
      OP_JAL: begin
        is_jal = 1'b1; regwrite = 1'b1; memtoreg = 2'b10;
      end
      default: valid = 1'b0;
    endcase
    if (if_id_instr == NOP_WORD) valid = 1'b0;
  end

  assign dest    = is_jal ? LINK_REG : (regdst_rd ? rd : rt);
  assign rt_used = valid && uses_rt;

  // The rs field is compared for every instruction; rt only where it is a true source.
  assign load_use  = id_ex_ctrl_q[1] && (id_ex_rt_q != 5'd0) &&
                     ((id_ex_rt_q == rs) || (rt_used && id_ex_rt_q == rt));
  assign jr_hazard = valid && is_jr && id_ex_ctrl_q[0] && (id_ex_rd_q != 5'd0) && (id_ex_rd_q == rs);
`ifdef REGFILE_BYPASS_EN
  assign wb_hazard = 1'b0;
`else
  assign wb_hazard = wb_regwrite && (wb_rd != 5'd0) && ((wb_rd == rs) || (rt_used && wb_rd == rt));
`endif
  assign stall = load_use || jr_hazard || wb_hazard;
  assign jump  = valid && (is_j || is_jal || is_jr);

  always_comb begin
    pc_keep        = 1'b0;
    dojump         = 1'b0;
    next_condition = NC_GO;
    bubble         = !valid;
    jumpaddress    = '0;
    if (jump) jumpaddress = is_jr ? rs_data : {if_id_pc4[31:28], if_id_instr[25:0], 2'b00};
    if (ex_dobranch) begin
      next_condition = NC_FLUSH;
      bubble         = 1'b1;
    end else if (stall) begin
      next_condition = NC_KEEP;
      pc_keep        = 1'b1;
      bubble         = 1'b1;
    end else if (jump) begin
      next_condition = NC_FLUSH;
      dojump         = 1'b1;
    end
  end

  always_comb begin
    id_ex_pc4_d     = '0;
    id_ex_rs_data_d = '0;
    id_ex_rt_data_d = '0;
    id_ex_imm_d     = '0;
    id_ex_rs_d      = '0;
    id_ex_rt_d      = '0;
    id_ex_rd_d      = '0;
    id_ex_ctrl_d    = '0;
    if (!bubble) begin
      id_ex_pc4_d     = if_id_pc4;
      id_ex_rs_data_d = rs_data;
      id_ex_rt_data_d = rt_data;
      id_ex_imm_d     = imm_ext;
      id_ex_rs_d      = rs;
      id_ex_rt_d      = rt;
      id_ex_rd_d      = dest;
      id_ex_ctrl_d    = {regdst_rd, aluop, branch, alusrc, memtoreg, memwrite, memread, regwrite};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      id_ex_pc4_q     <= '0;
      id_ex_rs_data_q <= '0;
      id_ex_rt_data_q <= '0;
      id_ex_imm_q     <= '0;
      id_ex_rs_q      <= '0;
      id_ex_rt_q      <= '0;
      id_ex_rd_q      <= '0;
      id_ex_ctrl_q    <= '0;
    end else begin
      id_ex_pc4_q     <= id_ex_pc4_d;
      id_ex_rs_data_q <= id_ex_rs_data_d;
      id_ex_rt_data_q <= id_ex_rt_data_d;
      id_ex_imm_q     <= id_ex_imm_d;
      id_ex_rs_q      <= id_ex_rs_d;
      id_ex_rt_q      <= id_ex_rt_d;
      id_ex_rd_q      <= id_ex_rd_d;
      id_ex_ctrl_q    <= id_ex_ctrl_d;
    end
  end

  assign id_ex_pc4     = id_ex_pc4_q;
  assign id_ex_rs_data = id_ex_rs_data_q;
  assign id_ex_rt_data = id_ex_rt_data_q;
  assign id_ex_imm     = id_ex_imm_q;
  assign id_ex_rs      = id_ex_rs_q;
  assign id_ex_rt      = id_ex_rt_q;
  assign id_ex_rd      = id_ex_rd_q;
  assign id_ex_ctrl    = id_ex_ctrl_q;

endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - scoreboard bench for id_stage: decode, hazards, jumps, resets, write-back reads
`timescale 1ns/1ps
module tb_id_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] if_id_pc4, if_id_instr, wb_data;
  logic        ex_dobranch, wb_regwrite;
  logic [4:0]  wb_rd;
  logic        pc_keep, dojump;
  logic [31:0] jumpaddress;
  logic [1:0]  next_condition;
  logic [31:0] id_ex_pc4, id_ex_rs_data, id_ex_rt_data, id_ex_imm;
  logic [4:0]  id_ex_rs, id_ex_rt, id_ex_rd;
  logic [11:0] id_ex_ctrl;

  id_stage dut (
    .clk(clk), .reset(reset), .if_id_pc4(if_id_pc4), .if_id_instr(if_id_instr),
    .ex_dobranch(ex_dobranch), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
    .pc_keep(pc_keep), .dojump(dojump), .jumpaddress(jumpaddress), .next_condition(next_condition),
    .id_ex_pc4(id_ex_pc4), .id_ex_rs_data(id_ex_rs_data), .id_ex_rt_data(id_ex_rt_data),
    .id_ex_imm(id_ex_imm), .id_ex_rs(id_ex_rs), .id_ex_rt(id_ex_rt), .id_ex_rd(id_ex_rd),
    .id_ex_ctrl(id_ex_ctrl)
  );

  always #5 clk = ~clk;

  localparam logic [31:0]  NOP = 32'h0;
  localparam logic [154:0] BUBBLE = '0;
  localparam logic [3:0]   A_ADD = 4'd1, A_SUB = 4'd2, A_AND = 4'd3, A_OR = 4'd4, A_SLT = 4'd5, A_LUI = 4'd6;

  typedef struct {
    logic         rst;
    logic [31:0]  pc4, instr;
    logic         br, wbe;
    logic [4:0]   wrd;
    logic [31:0]  wdata;
    logic [1:0]   nc;
    logic         keep, dj;
    logic [31:0]  ja;
    logic [154:0] idex;
  } step_t;

  int n_checks = 0;
  int n_fail   = 0;
  logic [154:0] sb[$];
  step_t        steps[$];
  logic [154:0] exp_idex;

  wire [154:0] idex_bus = {id_ex_pc4, id_ex_rs_data, id_ex_rt_data, id_ex_imm,
                           id_ex_rs, id_ex_rt, id_ex_rd, id_ex_ctrl};

  function automatic logic [11:0] ctrl(input logic rdsel, input logic [3:0] op, input logic br,
                                       input logic asrc, input logic [1:0] m2r, input logic mw,
                                       input logic mr, input logic rw);
    return {rdsel, op, br, asrc, m2r, mw, mr, rw};
  endfunction

  function automatic logic [154:0] ie(input logic [31:0] pc4, input logic [31:0] rsd, input logic [31:0] rtd,
                                      input logic [31:0] imm, input logic [4:0] rs, input logic [4:0] rt,
                                      input logic [4:0] rd, input logic [11:0] c);
    return {pc4, rsd, rtd, imm, rs, rt, rd, c};
  endfunction

  function automatic step_t mk(input logic rst, input logic [31:0] pc4, input logic [31:0] instr,
                               input logic br, input logic wbe, input logic [4:0] wrd,
                               input logic [31:0] wdata, input logic [1:0] nc, input logic keep,
                               input logic dj, input logic [31:0] ja, input logic [154:0] idex);
    step_t s;
    s.rst = rst; s.pc4 = pc4; s.instr = instr; s.br = br; s.wbe = wbe; s.wrd = wrd;
    s.wdata = wdata; s.nc = nc; s.keep = keep; s.dj = dj; s.ja = ja; s.idex = idex;
    return s;
  endfunction

  function automatic step_t wb(input logic [4:0] r, input logic [31:0] d);
    return mk(1, 0, NOP, 0, 1, r, d, 2'b00, 0, 0, 0, BUBBLE);
  endfunction

  function automatic step_t go(input logic [31:0] pc4, input logic [31:0] instr, input logic [154:0] idex);
    return mk(1, pc4, instr, 0, 0, 0, 0, 2'b00, 0, 0, 0, idex);
  endfunction

  function automatic step_t stall_on(input logic [31:0] pc4, input logic [31:0] instr, input logic wbe,
                                     input logic [4:0] wrd, input logic [31:0] wdata);
    return mk(1, pc4, instr, 0, wbe, wrd, wdata, 2'b10, 1, 0, 0, BUBBLE);
  endfunction

  task automatic apply(input step_t s);
    @(negedge clk);
    reset = s.rst; if_id_pc4 = s.pc4; if_id_instr = s.instr; ex_dobranch = s.br;
    wb_regwrite = s.wbe; wb_rd = s.wrd; wb_data = s.wdata;
  endtask

  task automatic test_reset();
    steps.push_back(mk(0, 0, NOP, 0, 0, 0, 0, 2'b00, 0, 0, 0, BUBBLE));
    steps.push_back(mk(0, 32'h44, 32'h00A53020, 0, 0, 0, 0, 2'b00, 0, 0, 0, BUBBLE));
    foreach (steps[i]) begin
      apply(steps[i]);
      sb.push_back(steps[i].idex);
      #1;
      n_checks++;
      if ({next_condition, pc_keep, dojump} !== {steps[i].nc, steps[i].keep, steps[i].dj}) begin
        n_fail++;
        $display("FAIL reset_ctl step %0d: got nc=%b keep=%b jump=%b, want nc=%b keep=%b jump=%b", i,
                 next_condition, pc_keep, dojump, steps[i].nc, steps[i].keep, steps[i].dj);
      end
      @(posedge clk); #1;
      exp_idex = sb.pop_front();
      n_checks++;
      if (idex_bus !== exp_idex) begin
        n_fail++;
        $display("FAIL reset_idex step %0d: got %h want %h", i, idex_bus, exp_idex);
      end
    end
    steps.delete();
  endtask

  task automatic test_decode_back_to_back();
    steps.push_back(wb(1, 100));
    steps.push_back(wb(2, 200));
    steps.push_back(go(32'h3004, 32'h2024FFFC, ie(32'h3004, 100, 0, 32'hFFFF_FFFC, 1, 4, 4, ctrl(0, A_ADD, 0, 1, 2'b00, 0, 0, 1))));
    steps.push_back(go(32'h3008, 32'h30248001, ie(32'h3008, 100, 0, 32'h0000_8001, 1, 4, 4, ctrl(0, A_AND, 0, 1, 2'b00, 0, 0, 1))));
    steps.push_back(go(32'h300C, 32'h34248001, ie(32'h300C, 100, 0, 32'h0000_8001, 1, 4, 4, ctrl(0, A_OR, 0, 1, 2'b00, 0, 0, 1))));
    steps.push_back(go(32'h3010, 32'h3C041234, ie(32'h3010, 0, 0, 32'h1234_0000, 0, 4, 4, ctrl(0, A_LUI, 0, 1, 2'b00, 0, 0, 1))));
    steps.push_back(go(32'h3014, 32'h0022202A, ie(32'h3014, 100, 200, 32'h202A, 1, 2, 4, ctrl(1, A_SLT, 0, 0, 2'b00, 0, 0, 1))));
    steps.push_back(go(32'h3018, 32'h00222022, ie(32'h3018, 100, 200, 32'h2022, 1, 2, 4, ctrl(1, A_SUB, 0, 0, 2'b00, 0, 0, 1))));
    steps.push_back(go(32'h301C, 32'h00222024, ie(32'h301C, 100, 200, 32'h2024, 1, 2, 4, ctrl(1, A_AND, 0, 0, 2'b00, 0, 0, 1))));
    steps.push_back(go(32'h3020, 32'h00222025, ie(32'h3020, 100, 200, 32'h2025, 1, 2, 4, ctrl(1, A_OR, 0, 0, 2'b00, 0, 0, 1))));
    steps.push_back(go(32'h3024, 32'hAC220008, ie(32'h3024, 100, 200, 32'h8, 1, 2, 2, ctrl(0, A_ADD, 0, 1, 2'b00, 1, 0, 0))));
    steps.push_back(go(32'h3028, 32'h1022FFFF, ie(32'h3028, 100, 200, 32'hFFFF_FFFF, 1, 2, 2, ctrl(0, A_SUB, 1, 0, 2'b00, 0, 0, 0))));
    steps.push_back(go(32'h302C, 32'hFC22FFFF, BUBBLE));
    steps.push_back(go(32'h3030, 32'h00222021, BUBBLE));
    foreach (steps[i]) begin
      apply(steps[i]);
      sb.push_back(steps[i].idex);
      #1;
      n_checks++;
      if ({next_condition, pc_keep, dojump} !== {steps[i].nc, steps[i].keep, steps[i].dj}) begin
        n_fail++;
        $display("FAIL decode_ctl step %0d: got nc=%b keep=%b jump=%b, want nc=%b keep=%b jump=%b", i,
                 next_condition, pc_keep, dojump, steps[i].nc, steps[i].keep, steps[i].dj);
      end
      @(posedge clk); #1;
      exp_idex = sb.pop_front();
      n_checks++;
      if (idex_bus !== exp_idex) begin
        n_fail++;
        $display("FAIL decode_idex step %0d: got %h want %h", i, idex_bus, exp_idex);
      end
    end
    steps.delete();
  endtask

  task automatic test_reset_midrun();
    steps.push_back(wb(5, 7));
    steps.push_back(go(32'h50, 32'h00A53020, ie(32'h50, 7, 7, 32'h3020, 5, 5, 6, ctrl(1, A_ADD, 0, 0, 2'b00, 0, 0, 1))));
    steps.push_back(mk(0, 32'h50, 32'h00A53020, 0, 0, 0, 0, 2'b00, 0, 0, 0, BUBBLE));
    steps.push_back(mk(0, 32'h50, 32'h00A53020, 0, 0, 0, 0, 2'b00, 0, 0, 0, BUBBLE));
    steps.push_back(go(32'h50, 32'h00A53020, ie(32'h50, 0, 0, 32'h3020, 5, 5, 6, ctrl(1, A_ADD, 0, 0, 2'b00, 0, 0, 1))));
    foreach (steps[i]) begin
      apply(steps[i]);
      sb.push_back(steps[i].idex);
      #1;
      n_checks++;
      if ({next_condition, pc_keep, dojump} !== {steps[i].nc, steps[i].keep, steps[i].dj}) begin
        n_fail++;
        $display("FAIL midreset_ctl step %0d: got nc=%b keep=%b jump=%b, want nc=%b keep=%b jump=%b", i,
                 next_condition, pc_keep, dojump, steps[i].nc, steps[i].keep, steps[i].dj);
      end
      @(posedge clk); #1;
      exp_idex = sb.pop_front();
      n_checks++;
      if (idex_bus !== exp_idex) begin
        n_fail++;
        $display("FAIL midreset_idex step %0d: got %h want %h", i, idex_bus, exp_idex);
      end
    end
    steps.delete();
  endtask

  task automatic test_load_use();
    logic [11:0] c_lw, c_add;
    c_lw  = ctrl(0, A_ADD, 0, 1, 2'b01, 0, 1, 1);
    c_add = ctrl(1, A_ADD, 0, 0, 2'b00, 0, 0, 1);
    steps.push_back(wb(1, 32'h40));
    steps.push_back(wb(2, 5));
    steps.push_back(go(32'h200, 32'h8C280000, ie(32'h200, 32'h40, 0, 0, 1, 8, 8, c_lw)));
    steps.push_back(stall_on(32'h204, 32'h01024820, 0, 0, 0));
    steps.push_back(go(32'h204, 32'h01024820, ie(32'h204, 0, 5, 32'h4820, 8, 2, 9, c_add)));
    steps.push_back(go(32'h208, 32'h8C280000, ie(32'h208, 32'h40, 0, 0, 1, 8, 8, c_lw)));
    steps.push_back(mk(0, 32'h20C, 32'h01024820, 0, 0, 0, 0, 2'b00, 0, 0, 0, BUBBLE));
    steps.push_back(mk(0, 32'h20C, 32'h01024820, 0, 0, 0, 0, 2'b00, 0, 0, 0, BUBBLE));
    steps.push_back(go(32'h20C, 32'h01024820, ie(32'h20C, 0, 0, 32'h4820, 8, 2, 9, c_add)));
    steps.push_back(go(32'h210, 32'h8C280000, ie(32'h210, 0, 0, 0, 1, 8, 8, c_lw)));
    steps.push_back(go(32'h214, 32'h20680001, ie(32'h214, 0, 0, 1, 3, 8, 8, ctrl(0, A_ADD, 0, 1, 2'b00, 0, 0, 1))));
    foreach (steps[i]) begin
      apply(steps[i]);
      sb.push_back(steps[i].idex);
      #1;
      n_checks++;
      if ({next_condition, pc_keep, dojump} !== {steps[i].nc, steps[i].keep, steps[i].dj}) begin
        n_fail++;
        $display("FAIL loaduse_ctl step %0d: got nc=%b keep=%b jump=%b, want nc=%b keep=%b jump=%b", i,
                 next_condition, pc_keep, dojump, steps[i].nc, steps[i].keep, steps[i].dj);
      end
      @(posedge clk); #1;
      exp_idex = sb.pop_front();
      n_checks++;
      if (idex_bus !== exp_idex) begin
        n_fail++;
        $display("FAIL loaduse_idex step %0d: got %h want %h", i, idex_bus, exp_idex);
      end
    end
    steps.delete();
  endtask

  task automatic test_jumps();
    logic [154:0] jr_idex;
    jr_idex = ie(32'h404, 32'h2000, 0, 32'h8, 31, 0, 0, 12'h0);
    steps.push_back(mk(1, 32'h1004, 32'h08000040, 0, 0, 0, 0, 2'b01, 0, 1, 32'h100,
                       ie(32'h1004, 0, 0, 32'h40, 0, 0, 0, 12'h0)));
    steps.push_back(mk(1, 32'h1004, 32'h08000040, 1, 0, 0, 0, 2'b01, 0, 0, 0, BUBBLE));
    steps.push_back(mk(1, 32'h2000, 32'h0C000100, 0, 0, 0, 0, 2'b01, 0, 1, 32'h400,
                       ie(32'h2000, 0, 0, 32'h100, 0, 0, 31, ctrl(0, 4'd0, 0, 0, 2'b10, 0, 0, 1))));
    steps.push_back(stall_on(32'h404, 32'h03E00008, 0, 0, 0));
`ifdef REGFILE_BYPASS_EN
    steps.push_back(mk(1, 32'h404, 32'h03E00008, 0, 1, 31, 32'h2000, 2'b01, 0, 1, 32'h2000, jr_idex));
`else
    steps.push_back(stall_on(32'h404, 32'h03E00008, 1, 31, 32'h2000));
    steps.push_back(mk(1, 32'h404, 32'h03E00008, 0, 0, 0, 0, 2'b01, 0, 1, 32'h2000, jr_idex));
`endif
    steps.push_back(mk(1, 32'hA000_1004, 32'h08000040, 0, 0, 0, 0, 2'b01, 0, 1, 32'hA000_0100,
                       ie(32'hA000_1004, 0, 0, 32'h40, 0, 0, 0, 12'h0)));
    foreach (steps[i]) begin
      apply(steps[i]);
      sb.push_back(steps[i].idex);
      #1;
      n_checks++;
      if ({next_condition, pc_keep, dojump} !== {steps[i].nc, steps[i].keep, steps[i].dj}) begin
        n_fail++;
        $display("FAIL jump_ctl step %0d: got nc=%b keep=%b jump=%b, want nc=%b keep=%b jump=%b", i,
                 next_condition, pc_keep, dojump, steps[i].nc, steps[i].keep, steps[i].dj);
      end
      if (steps[i].dj) begin
        n_checks++;
        if (jumpaddress !== steps[i].ja) begin
          n_fail++;
          $display("FAIL jump_target step %0d: got %h want %h", i, jumpaddress, steps[i].ja);
        end
      end
      @(posedge clk); #1;
      exp_idex = sb.pop_front();
      n_checks++;
      if (idex_bus !== exp_idex) begin
        n_fail++;
        $display("FAIL jump_idex step %0d: got %h want %h", i, idex_bus, exp_idex);
      end
    end
    steps.delete();
  endtask

  task automatic test_writeback_read();
    logic [11:0] c_add;
    c_add = ctrl(1, A_ADD, 0, 0, 2'b00, 0, 0, 1);
`ifdef REGFILE_BYPASS_EN
    steps.push_back(mk(1, 32'h600, 32'h00602020, 0, 1, 3, 32'hDEAD_BEEF, 2'b00, 0, 0, 0,
                       ie(32'h600, 32'hDEAD_BEEF, 0, 32'h2020, 3, 0, 4, c_add)));
    steps.push_back(mk(1, 32'h608, 32'h00032020, 0, 1, 3, 32'h55, 2'b00, 0, 0, 0,
                       ie(32'h608, 0, 32'h55, 32'h2020, 0, 3, 4, c_add)));
`else
    steps.push_back(stall_on(32'h600, 32'h00602020, 1, 3, 32'hDEAD_BEEF));
    steps.push_back(go(32'h600, 32'h00602020, ie(32'h600, 32'hDEAD_BEEF, 0, 32'h2020, 3, 0, 4, c_add)));
    steps.push_back(stall_on(32'h608, 32'h00032020, 1, 3, 32'h55));
    steps.push_back(go(32'h608, 32'h00032020, ie(32'h608, 0, 32'h55, 32'h2020, 0, 3, 4, c_add)));
`endif
    steps.push_back(mk(1, 32'h604, 32'h00002020, 0, 1, 0, 32'h1234, 2'b00, 0, 0, 0,
                       ie(32'h604, 0, 0, 32'h2020, 0, 0, 4, c_add)));
    steps.push_back(go(32'h604, 32'h00002020, ie(32'h604, 0, 0, 32'h2020, 0, 0, 4, c_add)));
`ifdef REGFILE_BYPASS_EN
    steps.push_back(mk(1, 32'h60C, 32'h20070001, 0, 1, 7, 32'h77, 2'b00, 0, 0, 0,
                       ie(32'h60C, 0, 32'h77, 1, 0, 7, 7, ctrl(0, A_ADD, 0, 1, 2'b00, 0, 0, 1))));
`else
    steps.push_back(mk(1, 32'h60C, 32'h20070001, 0, 1, 7, 32'h77, 2'b00, 0, 0, 0,
                       ie(32'h60C, 0, 0, 1, 0, 7, 7, ctrl(0, A_ADD, 0, 1, 2'b00, 0, 0, 1))));
`endif
    foreach (steps[i]) begin
      apply(steps[i]);
      sb.push_back(steps[i].idex);
      #1;
      n_checks++;
      if ({next_condition, pc_keep, dojump} !== {steps[i].nc, steps[i].keep, steps[i].dj}) begin
        n_fail++;
        $display("FAIL wbread_ctl step %0d: got nc=%b keep=%b jump=%b, want nc=%b keep=%b jump=%b", i,
                 next_condition, pc_keep, dojump, steps[i].nc, steps[i].keep, steps[i].dj);
      end
      @(posedge clk); #1;
      exp_idex = sb.pop_front();
      n_checks++;
      if (idex_bus !== exp_idex) begin
        n_fail++;
        $display("FAIL wbread_idex step %0d: got %h want %h", i, idex_bus, exp_idex);
      end
    end
    steps.delete();
  endtask

  initial begin
    reset = 1'b0; if_id_pc4 = '0; if_id_instr = NOP; ex_dobranch = 1'b0;
    wb_regwrite = 1'b0; wb_rd = '0; wb_data = '0;
    test_reset();
    test_decode_back_to_back();
    test_reset_midrun();
    test_load_use();
    test_jumps();
    test_writeback_read();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Instruction-decode stage of the 5-stage MIPS pipeline, directly downstream of the fetch stage.
- Consumes the IF/ID register contents (pc+4, instruction).
- Holds the 32x32 register file, decodes control, resolves j/jal/jr, and detects load-use hazards.
- Drives the fetch-stage controls (pc_keep, dojump, jumpaddress, next_condition) and owns the ID/EX pipeline register.

Parameters:
LINK_REG, 31, destination register written by jal
NOP_WORD, 32'h0000_0000, instruction word treated as a bubble (all ctrl bits 0)

Ports:
clk  in  1  pipeline clock, all state on rising edge
reset  in  1  asynchronous, active-low; 0 clears all state immediately
if_id_pc4  in  32  pc+4 of the instruction in ID
if_id_instr  in  32  instruction in ID
ex_dobranch  in  1  branch taken, resolved in EX this cycle
wb_regwrite  in  1  write-back enable
wb_rd  in  5  write-back register
wb_data  in  32  write-back data
pc_keep  out  1  hold PC (combinational)
dojump  out  1  jump taken in ID (combinational)
jumpaddress  out  32  jump target (combinational)
next_condition  out  2  IF/ID control: 00 go, 01 flush, 10 keep (combinational)
id_ex_pc4  out  32  registered pc+4
id_ex_rs_data  out  32  registered rs read data
id_ex_rt_data  out  32  registered rt read data
id_ex_imm  out  32  registered extended immediate
id_ex_rs  out  5  registered rs index
id_ex_rt  out  5  registered rt index
id_ex_rd  out  5  registered destination (rd / rt / LINK_REG)
id_ex_ctrl  out  12  registered control: [0] regwrite, [1] memread, [2] memwrite, [4:3] memtoreg (00 alu, 01 mem, 10 pc4), [5] alusrc, [6] branch, [10:7] aluop, [11] regdst_rd

Behaviour:
- Reset (reset=0, async): all id_ex_* outputs = 0; register file entries all 0. Combinational outputs follow from the zeroed state.
- Decoded set: R-type add, sub, and, or, slt, jr; lw, sw, beq, addi, andi, ori, lui, j, jal. Any other opcode decodes as a bubble (ctrl = 0).
- Immediate extension:
  - andi and ori: zero-extend.
  - lui: {imm16, 16'h0}.
  - All others: sign-extend.
- Register file:
  - Two combinational read ports, rs and rt.
  - One write port on the clk edge when wb_regwrite=1 and wb_rd != 0.
  - Register $0 always reads 0.
- Jumps, resolved in ID (0-cycle latency to IF):
  - j/jal: target {if_id_pc4[31:28], instr[25:0], 2'b00}.
  - jr: target is the rs read value.
  - jal: id_ex_rd=LINK_REG, memtoreg=10, regwrite=1.
- Load-use hazard (stall): id_ex_ctrl[1]=1 and id_ex_rt != 0 and id_ex_rt matches the ID rs or rt.
  - rt counts only for R-type, sw, and beq.
- jr hazard (stall): id_ex_ctrl[0]=1 and id_ex_rd == ID rs != 0.
- Priority, evaluated combinationally each cycle:
  - ex_dobranch=1: next_condition=01, pc_keep=0, dojump=0; bubble loaded into ID/EX.
  - else stall: next_condition=10, pc_keep=1, dojump=0; bubble loaded into ID/EX.
  - else j/jal/jr: dojump=1, next_condition=01; the jump instruction itself enters ID/EX normally.
  - else: next_condition=00, pc_keep=0; ID/EX loads the decoded instruction.
- Bubble: every id_ex_* field = 0.
- Stall duration: one cycle for load-use. jr stalls until the producer leaves EX.
- Reset mid-stall: stall is abandoned; ID/EX is zero on release.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: register file is write-first. A read whose index equals wb_rd (nonzero, wb_regwrite=1) returns wb_data in the same cycle.
- Undefined: reads return the stored value. The hazard unit adds a stall (next_condition=10, pc_keep=1, bubble) whenever wb_regwrite=1, wb_rd != 0, and wb_rd matches the ID rs or used rt.
  - This stall ranks after ex_dobranch and before jumps.

Test Plan:
- Reset: hold reset=0 mid-run for 2 cycles -> all id_ex_* = 0, next_condition=00, pc_keep=0. $5 previously written with 7 reads 0 after release.
- Load-use: lw $8,0($1) in EX, then add $9,$8,$2 in ID -> next_condition=10, pc_keep=1, id_ex_ctrl=0 for one cycle. Next cycle the add issues with id_ex_rs=8.
- Jump: instr 0x0800_0040 (j) with if_id_pc4=0x0000_1004 -> dojump=1, jumpaddress=0x0000_0100, next_condition=01.
- jal/jr: jal writes LINK_REG (id_ex_rd=31, memtoreg=10). A following jr $31 while jal is in EX -> 1-cycle stall, then jumpaddress = written value.
- Branch override: ex_dobranch=1 while j is in ID -> dojump=0, next_condition=01, ID/EX bubble.
- Write-back/read same cycle: wb $3=0xDEAD_BEEF while ID reads $3 -> id_ex_rs_data=0xDEAD_BEEF with REGFILE_BYPASS_EN. Without the macro, one stall, then 0xDEAD_BEEF. A wb to $0 leaves $0 reading 0.
